// File: rtl/acc_pkg.sv
// Shared types and constants for the edge-detection accelerator.
// The memory arbiter's optional read-after-write forwarding is enabled by RAW_FWD_EN.
package acc_pkg;

  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned IMG_WORDS_PER_ROW = 88;

  typedef logic [ADDR_W-1:0] halfword_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {
    ARB,
    DRAIN
  } arb_state_t;

  typedef struct packed {
    halfword_t addr;
    word_t     data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Circular write-buffer FIFO of {addr, data} entries; exposes every slot,
// per-slot valid bits and the read pointer so the arbiter can search for hazards.
module wbuf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 32,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [AW-1:0]               push_addr,
  input  logic [DW-1:0]               push_data,
  input  logic                        pop,
  output logic [CW-1:0]               count,
  output logic [PW-1:0]               rd_ptr,
  output logic [DEPTH-1:0]            valid,
  output logic [DEPTH-1:0][AW-1:0]    ent_addr,
  output logic [DEPTH-1:0][DW-1:0]    ent_data
);

  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale slots are masked by the valid bits.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= push_addr;
      ent_data[wr_ptr] <= push_data;
    end
  end

  // A slot is live when its distance from the head (mod DEPTH) is below count.
  always_comb begin
    logic [PW-1:0] off;
    off   = '0;
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - rd_ptr;
      valid[i] = CW'(off) < count;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter: pixel-fetch reads take priority, result writes are
// posted into wbuf_fifo and drained on idle cycles. Define RAW_FWD_EN to forward hazard reads.
module mem_arb #(
  parameter int unsigned ADDR_W     = acc_pkg::ADDR_W,
  parameter int unsigned DATA_W     = acc_pkg::DATA_W,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              flush,
  output logic              flush_done,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataR,
  output logic [DATA_W-1:0] dataW,
  output logic              en,
  output logic              we
);

  localparam int unsigned PW = $clog2(WBUF_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(WBUF_DEPTH);

  acc_pkg::arb_state_t state_q, state_d;

  logic [CW-1:0]                      count;
  logic [PW-1:0]                      rd_ptr;
  logic [WBUF_DEPTH-1:0]              valid;
  logic [WBUF_DEPTH-1:0][ADDR_W-1:0]  ent_addr;
  logic [WBUF_DEPTH-1:0][DATA_W-1:0]  ent_data;
  logic                               pop;
  logic                               hit;
  logic                               hazard;
  logic                               drain_on_hazard;

  wbuf_fifo #(
    .DEPTH (WBUF_DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_ack),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (pop),
    .count     (count),
    .rd_ptr    (rd_ptr),
    .valid     (valid),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      if (valid[i] && (ent_addr[i] == rd_addr)) hit = 1'b1;
    end
  end

  assign hazard = rd_req & hit;

`ifdef RAW_FWD_EN
  logic              fwd_hit;
  logic              fwd_q;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] fwd_data_q;

  assign drain_on_hazard = 1'b0;

  // Walk oldest to youngest so the last match (youngest write) wins.
  always_comb begin
    logic [PW-1:0] slot;
    slot     = '0;
    fwd_data = '0;
    for (int unsigned k = 0; k < WBUF_DEPTH; k++) begin
      slot = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (ent_addr[slot] == rd_addr)) fwd_data = ent_data[slot];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q <= fwd_hit;
      if (fwd_hit) fwd_data_q <= fwd_data;
    end
  end

  assign rd_data = fwd_q ? fwd_data_q : dataR;
`else
  assign drain_on_hazard = hazard;
  assign rd_data         = dataR;
`endif

  // Outputs are held low throughout reset regardless of requester inputs.
  always_comb begin
    state_d    = state_q;
    rd_gnt     = 1'b0;
    wr_ack     = 1'b0;
    flush_done = 1'b0;
    en         = 1'b0;
    we         = 1'b0;
    addr       = '0;
    dataW      = '0;
    pop        = 1'b0;
`ifdef RAW_FWD_EN
    fwd_hit    = 1'b0;
`endif
    if (!reset) begin
      wr_ack     = wr_req & (count < FULL);
      flush_done = flush & (count == '0) & ~wr_req;
      case (state_q)
        acc_pkg::ARB: begin
          if (rd_req & ~hazard & ~flush) begin
            rd_gnt = 1'b1;
            en     = 1'b1;
            addr   = rd_addr;
          end
`ifdef RAW_FWD_EN
          else if (rd_req & hazard & ~flush) begin
            rd_gnt  = 1'b1;
            fwd_hit = 1'b1;
          end
`endif
          else if (count != '0) begin
            pop   = 1'b1;
            en    = 1'b1;
            we    = 1'b1;
            addr  = ent_addr[rd_ptr];
            dataW = ent_data[rd_ptr];
          end
          if ((count == FULL) | flush | drain_on_hazard) state_d = acc_pkg::DRAIN;
        end
        acc_pkg::DRAIN: begin
          if (count != '0) begin
            pop   = 1'b1;
            en    = 1'b1;
            we    = 1'b1;
            addr  = ent_addr[rd_ptr];
            dataW = ent_data[rd_ptr];
          end else begin
            state_d = acc_pkg::ARB;
          end
        end
        default: state_d = acc_pkg::ARB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= acc_pkg::ARB;
      rd_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_valid <= rd_gnt;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural synchronous RAM and read/write
// scoreboards; covers both builds of RAW_FWD_EN.
module tb_mem_arb;
  import acc_pkg::*;

  logic              clk;
  logic              reset;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              flush;
  logic              flush_done;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataR;
  logic [DATA_W-1:0] dataW;
  logic              en;
  logic              we;

  int unsigned vectors;
  int unsigned miscompares;

  logic [DATA_W-1:0] mem     [0:65535];
  logic [DATA_W-1:0] ref_mem [0:65535];
  logic [DATA_W-1:0] exp_rd  [$];
  wbuf_entry_t       exp_wr  [$];

  mem_arb #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .WBUF_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .flush      (flush),
    .flush_done (flush_done),
    .addr       (addr),
    .dataR      (dataR),
    .dataW      (dataW),
    .en         (en),
    .we         (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears the cycle after an en & !we access.
  initial dataR = '0;
  always @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= dataW;
      else    dataR     <= mem[addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expectations are pushed on grant/accept and popped as the port produces them.
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    wbuf_entry_t       w;
    if (!reset) begin
      if (rd_valid) begin
        chk("rd_q_nonempty", 64'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) begin
          e = exp_rd.pop_front();
          chk("sb_rd_data", rd_data, e);
        end
      end
      if (rd_gnt) exp_rd.push_back(ref_mem[rd_addr]);
      if (en && we) begin
        chk("wr_q_nonempty", 64'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          chk("sb_wr_addr", addr, w.addr);
          chk("sb_wr_data", dataW, w.data);
        end
      end
      if (wr_ack) begin
        exp_wr.push_back('{addr: wr_addr, data: wr_data});
        ref_mem[wr_addr] = wr_data;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000;
      ref_mem[i] = (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000;
    end

    // Reset with requesters active: every output must stay low.
    reset = 1'b1; rd_req = 1'b1; rd_addr = '0; wr_req = 1'b1;
    wr_addr = 16'h1234; wr_data = '1; flush = 1'b0;
    cyc();
    @(negedge clk);
    chk("rst_en", en, 0);
    chk("rst_we", we, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_addr", addr, 0);
    chk("rst_dataW", dataW, 0);
    chk("rst_rd_valid", rd_valid, 0);
    cyc();
    reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    cyc();

    // Back-to-back reads.
    rd_req = 1'b1; rd_addr = 16'h0000;
    @(negedge clk);
    chk("rd0_gnt", {rd_gnt, en, we}, 3'b110);
    chk("rd0_addr", addr, 16'h0000);
    chk("rd0_valid_early", rd_valid, 0);
    cyc();
    rd_addr = 16'(IMG_WORDS_PER_ROW);
    @(negedge clk);
    chk("rd1_gnt", {rd_gnt, en, we}, 3'b110);
    chk("rd1_addr", addr, 16'h0058);
    chk("rd0_valid", rd_valid, 1);
    chk("rd0_data", rd_data, (32'h0 * 32'h0100_0193) ^ 32'hA5A5_0000);
    chk("rd_wr_idle", wr_ack, 0);
    cyc();
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_idle_en", en, 0);
    chk("rd_idle_addr", addr, 0);
    chk("rd1_valid", rd_valid, 1);
    cyc();
    @(negedge clk);
    chk("rd_valid_drop", rd_valid, 0);
    cyc();

    // Posted writes drain one per cycle starting the cycle after the push.
    for (int i = 0; i < 3; i++) begin
      wr_req = 1'b1; wr_addr = 16'h0100 + 16'(i); wr_data = 32'hC0DE_0000 + 32'(i);
      @(negedge clk);
      chk("pw_ack", wr_ack, 1);
      if (i == 0) chk("pw_idle_en", en, 0);
      else        chk("pw_mem", {en, we, addr}, {2'b11, 16'h0100 + 16'(i - 1)});
      cyc();
    end
    wr_req = 1'b0;
    @(negedge clk);
    chk("pw_mem_last", {en, we, addr}, {2'b11, 16'h0102});
    cyc();
    @(negedge clk);
    chk("pw_port_idle", en, 0);
    chk("pw_count", dut.u_wbuf.count, 0);
    cyc();

    // Full buffer while reads are held: fifth write refused, then a 4-cycle drain.
    rd_req = 1'b1; rd_addr = 16'h0200;
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1; wr_addr = 16'h0300 + 16'(i); wr_data = 32'hF000_0000 + 32'(i);
      @(negedge clk);
      chk("full_rd_gnt", rd_gnt, 1);
      chk("full_wr_ack", wr_ack, 64'(i < 4));
      cyc();
    end
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_mem", {en, we, addr}, {2'b11, 16'h0300 + 16'(i)});
      chk("drain_rd_gnt", rd_gnt, 0);
      chk("drain_state", 64'(dut.state_q), 64'(DRAIN));
      cyc();
    end
    @(negedge clk);
    chk("drain_exit_idle", {rd_gnt, en}, 2'b00);
    cyc();
    @(negedge clk);
    chk("drain_rd_resume", {rd_gnt, en, we}, 3'b110);
    chk("drain_rd_addr", addr, 16'h0200);
    cyc();
    rd_req = 1'b0;
    cyc();
    cyc();

    // Read-after-write hazard on a buffered entry.
    wr_req = 1'b1; wr_addr = 16'h0010; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("raw_wr_ack", wr_ack, 1);
    chk("raw_wr_idle", en, 0);
    cyc();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 16'h0010;
    @(negedge clk);
`ifdef RAW_FWD_EN
    chk("raw_fwd_gnt", rd_gnt, 1);
    chk("raw_fwd_no_mem", en, 0);
    cyc();
    rd_req = 1'b0;
    @(negedge clk);
    chk("raw_fwd_valid", rd_valid, 1);
    chk("raw_fwd_data", rd_data, 32'hDEAD_BEEF);
    chk("raw_fwd_wr", {en, we, addr}, {2'b11, 16'h0010});
    cyc();
`else
    chk("raw_hold_gnt", rd_gnt, 0);
    chk("raw_wr_first", {en, we, addr}, {2'b11, 16'h0010});
    cyc();
    @(negedge clk);
    chk("raw_drain_idle", {rd_gnt, en}, 2'b00);
    cyc();
    @(negedge clk);
    chk("raw_rd_gnt", rd_gnt, 1);
    chk("raw_rd_mem", {en, we, addr}, {2'b10, 16'h0010});
    cyc();
    rd_req = 1'b0;
    @(negedge clk);
    chk("raw_valid", rd_valid, 1);
    chk("raw_data", rd_data, 32'hDEAD_BEEF);
    cyc();
`endif
    cyc();

    // Flush: two buffered writes drain, reads are blocked, then flush_done.
    rd_req = 1'b1; rd_addr = 16'h0500;
    for (int i = 0; i < 2; i++) begin
      wr_req = 1'b1; wr_addr = 16'h0400 + 16'(i); wr_data = 32'hF1F1_0000 + 32'(i);
      @(negedge clk);
      chk("fl_pre_ack", {wr_ack, rd_gnt}, 2'b11);
      cyc();
    end
    wr_req = 1'b0; flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("fl_rd_blocked", rd_gnt, 0);
      chk("fl_mem", {en, we, addr}, {2'b11, 16'h0400 + 16'(i)});
      chk("fl_not_done", flush_done, 0);
      cyc();
    end
    @(negedge clk);
    chk("fl_done", flush_done, 1);
    chk("fl_idle", {rd_gnt, en}, 2'b00);
    cyc();
    flush = 1'b0; rd_req = 1'b0;
    cyc();

    // Reset while draining with three entries left.
    rd_req = 1'b1; rd_addr = 16'h0600;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_addr = 16'h0700 + 16'(i); wr_data = 32'h7777_0000 + 32'(i);
      @(negedge clk);
      chk("rs_fill_ack", wr_ack, 1);
      cyc();
    end
    wr_req = 1'b0;
    @(negedge clk);
    chk("rs_full_gnt", rd_gnt, 1);
    cyc();
    rd_req = 1'b0;
    cyc();
    chk("rs_pre_count", dut.u_wbuf.count, 3);
    chk("rs_pre_state", 64'(dut.state_q), 64'(DRAIN));
    reset = 1'b1;
    exp_wr.delete();
    #1;
    chk("rs_en", {en, we, rd_valid}, 3'b000);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rs_count", dut.u_wbuf.count, 0);
    chk("rs_state", 64'(dut.state_q), 64'(ARB));
    chk("rs_idle", en, 0);
    cyc();
    rd_req = 1'b1; rd_addr = 16'(IMG_WORDS_PER_ROW);
    @(negedge clk);
    chk("rs_rd_gnt", {rd_gnt, en, we}, 3'b110);
    cyc();
    rd_req = 1'b0;
    cyc();
    cyc();

    chk("end_rd_q", 64'(exp_rd.size()), 0);
    chk("end_wr_q", 64'(exp_wr.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
